// File: rtl/nvram_backup_pkg.sv
// nvram_backup_pkg: shared FSM state codes, transfer op type and sector sizing helper for nvram_backup_ctrl
package nvram_backup_pkg;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] ACK_WAIT  = 2'd2;
  localparam logic [1:0] DONE_WAIT = 2'd3;
  typedef enum logic {OP_LOAD = 1'b0, OP_SAVE = 1'b1} op_e;
  localparam int SECTOR_BYTES = 512;
  function automatic logic [63:0] sectors_of(input logic [63:0] bytes);
    return (bytes >> $clog2(SECTOR_BYTES)) + {63'd0, |(bytes & 64'(SECTOR_BYTES - 1))};
  endfunction
endpackage

// File: rtl/nvram_backup_ctrl_edge_det.sv
// edge_det: registered previous-value edge detector; rise/fall are valid in the cycle the input changes
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic d_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) d_q <= 1'b0;
    else d_q <= d;
  assign rise = d & ~d_q;
  assign fall = ~d & d_q;
endmodule

// File: rtl/nvram_backup_ctrl.sv
// nvram_backup_ctrl: sequences multi-sector NVRAM load/save over the HPS sector interface.
// Optional ack watchdog enabled by defining NVRAM_BACKUP_TIMEOUT_EN.
module nvram_backup_ctrl
  import nvram_backup_pkg::*;
#(
  parameter int NUM_SECTORS    = 64,
  parameter int SECT_W         = 8,
  parameter int LBA_W          = 32,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              download,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              autosave_en,
  input  logic              osd_status,
  input  logic              nvram_we,
  input  logic              sd_ack,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic [SECT_W-1:0] sect_idx,
  output logic              bk_ena,
  output logic              bk_loading,
  output logic              bk_busy,
  output logic              bk_pending,
  output logic              bk_error
);
  localparam int CW = SECT_W + 1;
  logic [1:0] state_q, state_d;
  op_e op_q, op_d;
  logic [SECT_W-1:0] idx_q, idx_d, last_q, last_d;
  logic rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, loading_q, loading_d;
  logic ena_q, ena_d, pend_q, pend_d;
  logic lr_rise, sr_rise, dl_rise, dl_fall, ack_rise, ack_fall, as_rise;
  logic lr_unused_fall, sr_unused_fall, as_unused_fall;
  logic [63:0] img_sect;
  logic [CW-1:0] load_n;
  logic idle, go_load, go_save;
  edge_det u_lr  (.clk(clk_sys), .rst(reset), .d(load_req), .rise(lr_rise), .fall(lr_unused_fall));
  edge_det u_sr  (.clk(clk_sys), .rst(reset), .d(save_req), .rise(sr_rise), .fall(sr_unused_fall));
  edge_det u_dl  (.clk(clk_sys), .rst(reset), .d(download), .rise(dl_rise), .fall(dl_fall));
  edge_det u_ack (.clk(clk_sys), .rst(reset), .d(sd_ack), .rise(ack_rise), .fall(ack_fall));
  edge_det u_as  (.clk(clk_sys), .rst(reset), .d(pend_q & osd_status & autosave_en),
                  .rise(as_rise), .fall(as_unused_fall));
  // Partial images load only the sectors they cover, never more than a full backup
  assign img_sect = sectors_of(img_size);
  assign load_n   = (img_sect > 64'(NUM_SECTORS)) ? CW'(NUM_SECTORS) : img_sect[CW-1:0];
  assign idle     = state_q == IDLE;
  assign go_load  = idle & ena_q & (lr_rise | dl_fall) & (load_n != '0);
  assign go_save  = idle & ena_q & ~go_load & (sr_rise | as_rise);
`ifdef NVRAM_BACKUP_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    last_d    = last_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    busy_d    = busy_q;
    loading_d = loading_q;
    ena_d     = (download & img_mounted & ~img_readonly) ? 1'b1 : dl_rise ? 1'b0 : ena_q;
    pend_d    = (ena_q & ~osd_status & nvram_we) ? 1'b1 : go_save ? 1'b0 : pend_q;
`ifdef NVRAM_BACKUP_TIMEOUT_EN
    cnt_d     = (state_q == ACK_WAIT || state_q == DONE_WAIT) ? cnt_q + 1'b1 : '0;
    err_d     = err_q;
`endif
    if (go_load || go_save) begin
      state_d   = REQ;
      op_d      = go_load ? OP_LOAD : OP_SAVE;
      idx_d     = '0;
      last_d    = go_load ? SECT_W'(load_n - 1'b1) : SECT_W'(NUM_SECTORS - 1);
      busy_d    = 1'b1;
      loading_d = go_load;
`ifdef NVRAM_BACKUP_TIMEOUT_EN
      err_d     = 1'b0;
`endif
    end else if (state_q == REQ) begin
      rd_d    = op_q == OP_LOAD;
      wr_d    = op_q == OP_SAVE;
      state_d = ACK_WAIT;
    end else if (state_q == ACK_WAIT && ack_rise) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      state_d = DONE_WAIT;
    end else if (state_q == DONE_WAIT && ack_fall) begin
      state_d   = (idx_q == last_q) ? IDLE : REQ;
      busy_d    = idx_q != last_q;
      loading_d = (idx_q != last_q) & loading_q;
      idx_d     = (idx_q == last_q) ? idx_q : idx_q + 1'b1;
    end
`ifdef NVRAM_BACKUP_TIMEOUT_EN
    if (cnt_d == 32'(TIMEOUT_CYCLES)) begin
      state_d   = IDLE;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      busy_d    = 1'b0;
      loading_d = 1'b0;
      err_d     = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_LOAD;
      idx_q     <= '0;
      last_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      loading_q <= 1'b0;
      ena_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      loading_q <= loading_d;
      ena_q     <= ena_d;
      pend_q    <= pend_d;
    end
`ifdef NVRAM_BACKUP_TIMEOUT_EN
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign bk_error = err_q;
`else
  assign bk_error = 1'b0;
`endif
  assign sd_lba     = LBA_W'(idx_q);
  assign sect_idx   = idx_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign bk_ena     = ena_q;
  assign bk_loading = loading_q;
  assign bk_busy    = busy_q;
  assign bk_pending = pend_q;
endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// tb_nvram_backup_ctrl: randomized self-checking bench with an HPS sector responder and a sector-count model
module tb_nvram_backup_ctrl;
  logic clk = 1'b0;
  logic reset, download, img_mounted, img_readonly, load_req, save_req;
  logic autosave_en, osd_status, nvram_we, sd_ack;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_pending, bk_error;
  logic [7:0] sect_idx;
  int checks = 0;
  int errors = 0;

  nvram_backup_ctrl dut (
    .clk_sys(clk), .reset(reset), .download(download), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size(img_size), .load_req(load_req), .save_req(save_req),
    .autosave_en(autosave_en), .osd_status(osd_status), .nvram_we(nvram_we), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sect_idx(sect_idx), .bk_ena(bk_ena),
    .bk_loading(bk_loading), .bk_busy(bk_busy), .bk_pending(bk_pending), .bk_error(bk_error)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  always @(negedge clk) begin
    checks++;
    if (sd_rd && sd_wr) begin
      errors++;
      $display("FAIL rd_wr_exclusive: sd_rd=%0b sd_wr=%0b, required not both 1", sd_rd, sd_wr);
    end
  end

  function automatic int exp_sectors(input longint unsigned sz);
    longint unsigned c = (sz + 511) / 512;
    return (c > 64) ? 64 : int'(c);
  endfunction

  // Acts as the HPS: services sectors 0..upto-1; stops with the last request still pending when upto < n
  task automatic serve(input bit ld, input int n, input int upto);
    for (int s = 0; s < upto; s++) begin
      int w = 0;
      while (!(sd_rd | sd_wr) && w < 20) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (!(sd_rd | sd_wr)) begin
        errors++;
        $display("FAIL req_missing: sector %0d got no request in 20 cycles, required one", s);
        return;
      end
      checks++;
      if (sd_rd !== ld || sd_wr !== !ld || sd_lba !== s || sect_idx !== s) begin
        errors++;
        $display("FAIL sector_req: rd=%0b wr=%0b lba=%0d idx=%0d, required rd=%0b wr=%0b lba=idx=%0d",
                 sd_rd, sd_wr, sd_lba, sect_idx, ld, !ld, s);
      end
      checks++;
      if (bk_busy !== 1'b1 || bk_loading !== ld) begin
        errors++;
        $display("FAIL busy_flags: busy=%0b loading=%0b, required busy=1 loading=%0b", bk_busy, bk_loading, ld);
      end
      if (s == upto - 1 && upto < n) return;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (sd_rd !== ld || sd_wr !== !ld) begin
        errors++;
        $display("FAIL req_held: rd=%0b wr=%0b before ack, required rd=%0b wr=%0b", sd_rd, sd_wr, ld, !ld);
      end
      sd_ack = 1'b1;
      @(negedge clk);
      checks++;
      if ((sd_rd | sd_wr) !== 1'b0) begin
        errors++;
        $display("FAIL req_drop: rd=%0b wr=%0b after ack rise, required 0", sd_rd, sd_wr);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sd_ack = 1'b0;
      @(negedge clk);
    end
    if (upto == n) begin
      checks++;
      if (bk_busy !== 1'b0 || bk_loading !== 1'b0) begin
        errors++;
        $display("FAIL done_flags: busy=%0b loading=%0b after last ack, required 0 0", bk_busy, bk_loading);
      end
      repeat (5) @(negedge clk);
      checks++;
      if ((sd_rd | sd_wr) !== 1'b0) begin
        errors++;
        $display("FAIL extra_sector: rd=%0b wr=%0b after %0d sectors, required idle", sd_rd, sd_wr, n);
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    repeat (4) @(negedge clk);
    checks++;
    if (bk_busy !== 1'b0 || (sd_rd | sd_wr) !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%0b rd=%0b wr=%0b, required no transfer", tag, bk_busy, sd_rd, sd_wr);
    end
  endtask

  task automatic mount(input longint unsigned size, input bit ro);
    download = 1'b1;
    @(negedge clk);
    checks++;
    if (bk_ena !== 1'b0) begin
      errors++;
      $display("FAIL ena_clear: bk_ena=%0b after download rise, required 0", bk_ena);
    end
    img_size = size;
    img_readonly = ro;
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
    @(negedge clk);
    checks++;
    if (bk_ena !== !ro) begin
      errors++;
      $display("FAIL ena_set: bk_ena=%0b after mount ro=%0b, required %0b", bk_ena, ro, !ro);
    end
    download = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (sd_rd !== 0 || sd_wr !== 0 || sd_lba !== 0 || sect_idx !== 0) begin
      errors++;
      $display("FAIL reset_sd: rd=%0b wr=%0b lba=%0d idx=%0d, required all 0", sd_rd, sd_wr, sd_lba, sect_idx);
    end
    checks++;
    if ({bk_ena, bk_loading, bk_busy, bk_pending, bk_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_bk: ena/load/busy/pend/err=%b, required 00000",
               {bk_ena, bk_loading, bk_busy, bk_pending, bk_error});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_download_load();
    mount(32768, 0);
    serve(1, exp_sectors(32768), exp_sectors(32768));
  endtask

  task automatic test_partial_images();
    mount(1536, 0);
    serve(1, exp_sectors(1536), exp_sectors(1536));
    mount(513, 0);
    serve(1, exp_sectors(513), exp_sectors(513));
  endtask

  task automatic test_readonly_and_empty();
    mount(4096, 1);
    expect_idle("readonly_no_load");
    mount(0, 0);
    expect_idle("empty_no_load");
  endtask

  task automatic test_autosave();
    autosave_en = 1'b0;
    osd_status = 1'b0;
    nvram_we = 1'b1;
    @(negedge clk);
    nvram_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bk_pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_set: bk_pending=%0b after nvram_we, required 1", bk_pending);
    end
    osd_status = 1'b1;
    expect_idle("autosave_disabled");
    checks++;
    if (bk_pending !== 1'b1) begin
      errors++;
      $display("FAIL pending_hold: bk_pending=%0b with autosave off, required 1", bk_pending);
    end
    autosave_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bk_pending !== 1'b0 || bk_busy !== 1'b1) begin
      errors++;
      $display("FAIL autosave_start: pending=%0b busy=%0b, required 0 1", bk_pending, bk_busy);
    end
    serve(0, 64, 64);
    nvram_we = 1'b1;
    @(negedge clk);
    nvram_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bk_pending !== 1'b0) begin
      errors++;
      $display("FAIL pending_osd: bk_pending=%0b on write with OSD open, required 0", bk_pending);
    end
    osd_status = 1'b0;
    autosave_en = 1'b0;
  endtask

  task automatic test_priority_and_drop();
    img_size = 1536;
    load_req = 1'b1;
    save_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bk_busy !== 1'b1 || bk_loading !== 1'b1) begin
      errors++;
      $display("FAIL load_priority: busy=%0b loading=%0b, required 1 1", bk_busy, bk_loading);
    end
    load_req = 1'b0;
    save_req = 1'b0;
    @(negedge clk);
    save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    serve(1, exp_sectors(1536), exp_sectors(1536));
  endtask

  task automatic test_random_loads();
    longint unsigned sizes[6];
    sizes[0] = 0;
    sizes[1] = 1;
    sizes[2] = 64'h0001_0000_0000_0000;
    sizes[3] = longint'($urandom_range(1, 70000));
    sizes[4] = longint'($urandom_range(1, 33000));
    sizes[5] = longint'($urandom_range(32768, 1 << 20));
    for (int i = 0; i < 6; i++) begin
      int n = exp_sectors(sizes[i]);
      img_size = sizes[i];
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      if (n == 0) expect_idle("zero_size_load");
      else serve(1, n, n);
    end
  endtask

  task automatic test_async_reset_mid_save();
    save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    serve(0, 64, 11);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sd_wr !== 1'b0 || bk_busy !== 1'b0 || sd_lba !== 0 || bk_ena !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: wr=%0b busy=%0b lba=%0d ena=%0b, required all 0", sd_wr, bk_busy, sd_lba, bk_ena);
    end
    @(negedge clk);
    reset = 1'b0;
    expect_idle("after_reset");
  endtask

  initial begin
    reset = 1'b1;
    download = 1'b0;
    img_mounted = 1'b0;
    img_readonly = 1'b0;
    img_size = '0;
    load_req = 1'b0;
    save_req = 1'b0;
    autosave_en = 1'b0;
    osd_status = 1'b0;
    nvram_we = 1'b0;
    sd_ack = 1'b0;
    test_reset();
    test_download_load();
    test_partial_images();
    test_readonly_and_empty();
    test_autosave();
    test_priority_and_drop();
    test_random_loads();
    test_async_reset_mid_save();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
